audio_capture_playback: RTL and testbench
=========================================

// Module: audio_capture_playback
// PURPOSE
// - Downstream of the PDM microphone front end: takes its amplitude/amplitude_valid stream.
// - Records amplitude samples into an on-chip RAM while record is held.
// - On a play pulse, replays the stored samples at the original sample rate as a PWM bit-stream for the audio amp.
// - Sits between the microphone front end and the board audio output pin.
// PARAMETERS
// - AMP_W         8      amplitude width; value range 0..2**(AMP_W-1) (0..128)
// - RAM_DEPTH     131072 sample capacity (~5.2 s at 25 kHz)
// - SAMPLE_PERIOD 4000   clk cycles between playback samples (100 MHz / 25 kHz)
// PORTS
// - clk             in   1          system clock, 100 MHz
// - rst             in   1          asynchronous reset, active-high
// - amplitude       in   AMP_W      sample from the PDM front end
// - amplitude_valid in   1          1-cycle strobe qualifying amplitude
// - record          in   1          level (debounced); high = record
// - play            in   1          1-cycle pulse; start playback
// - audio_pwm       out  1          PWM audio bit-stream
// - audio_en        out  1          amplifier enable; high only in PLAY
// - recording       out  1          high in RECORD
// - playing         out  1          high in PLAY
// - full            out  1          buffer reached RAM_DEPTH in last recording
// - length          out  clog2(RAM_DEPTH)+1  samples held from last recording
// BEHAVIOUR
// - Reset values: state IDLE; outputs audio_pwm, audio_en, recording, playing and full all 0; length 0.
// - Reset does not clear RAM contents. Reset mid-RECORD or mid-PLAY returns to IDLE with length 0.
// - FSM states: IDLE, RECORD, PLAY.
// - IDLE -> RECORD: record==1. Clears wr_addr, length and full.
// - IDLE -> PLAY: play==1, record==0 and length!=0. Clears rd_addr and the period counter.
// - play with length==0 is ignored. record has priority if it is high in the same cycle as play.
// - RECORD, per amplitude_valid: write ram[wr_addr], then wr_addr++ and length++.
// - RECORD -> IDLE: record==0 (a strobe in the same cycle is still written), or on the write that makes length==RAM_DEPTH (sets full=1).
// - If record is still held after full is set, stay in IDLE until record goes low; no re-entry.
// - PLAY: period counter counts 0..SAMPLE_PERIOD-1. At count 0, read ram[rd_addr]; the RAM has 1-cycle read latency.
// - The read data loads the PWM duty register one cycle later, then rd_addr++.
// - First duty load is <=3 cycles after the play pulse; later loads are exactly every SAMPLE_PERIOD cycles.
// - PLAY -> IDLE: after the duty load for rd_addr==length-1 has been held for one full SAMPLE_PERIOD. Duty then resets to 0.
// - PLAY: record and play inputs are ignored. RECORD: play is ignored; amplitude_valid is ignored outside RECORD.
// - PWM: free-running counter over 2**(AMP_W-1) cycles (128). audio_pwm = (pwm_cnt < duty).
// - PWM boundaries: duty 0 -> constant low; duty 128 -> constant high.
// - audio_pwm is registered and held at 0 outside PLAY.
// - Arithmetic: addresses are clog2(RAM_DEPTH) bits; length is one bit wider so RAM_DEPTH itself is representable. No wrap-around on write.
// STRUCTURE
// - Package audio_pkg holds:
//   - typedef enum {IDLE, RECORD, PLAY} audio_state_t
//   - AMP_W default constant
//   - amplitude_t typedef
// - One sub-module: pwm_gen (duty register, counter, compare; 1-cycle registered output).
// - RAM is inferred in this module as a simple dual-port block RAM (1 write port, 1 read port).
// TESTING
// - Bench parameters: RAM_DEPTH=16, SAMPLE_PERIOD=256 unless stated otherwise.
// - Record 10 strobes with amplitudes 0..9, then drop record:
//   -> length=10, full=0.
//   -> play: duty sequence 0..9, one value per 256 cycles.
//   -> playing falls after 2560 +/- 3 cycles.
// - Hold record for 20 strobes:
//   -> length=16, full=1, recording falls after the 16th write.
//   -> no re-entry to RECORD until record toggles low.
// - play pulse with length=0 -> stays IDLE; audio_en=0, audio_pwm=0 throughout.
// - record and play asserted in the same IDLE cycle -> RECORD entered; playing never asserts.
// - Assert rst mid-RECORD after 5 writes, then release:
//   -> IDLE, length=0; all outputs 0 in the cycle after reset asserts.
// - PWM duty check over one 128-cycle PWM period:
//   -> samples 0, 64, 128 give 0, 64, 128 high cycles respectively.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared FSM state type, default amplitude width and amplitude type
package audio_pkg;
  localparam int DEFAULT_AMP_W = 8;
  typedef logic [DEFAULT_AMP_W-1:0] amplitude_t;
  typedef enum logic [1:0] {IDLE, RECORD, PLAY} audio_state_t;
endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: duty register + free-running counter PWM; clk, rst, en (gate), load/duty_in (new duty), clr (duty to 0), pwm (registered out)
module pwm_gen #(
  parameter int AMP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             clr,
  input  logic [AMP_W-1:0] duty_in,
  output logic             pwm
);
  logic [AMP_W-1:0] duty;
  logic [AMP_W-2:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      cnt  <= '0;
      pwm  <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      duty <= clr ? '0 : load ? duty_in : duty;
      pwm  <= en && ({1'b0, cnt} < duty);
    end
  end
endmodule

// File: rtl/audio_capture_playback.sv
// audio_capture_playback: record amplitude stream to RAM, replay as PWM; clk, rst, amplitude/amplitude_valid, record, play in; audio_pwm, audio_en, recording, playing, full, length out
module audio_capture_playback
  import audio_pkg::*;
#(
  parameter int AMP_W         = DEFAULT_AMP_W,
  parameter int RAM_DEPTH     = 131072,
  parameter int SAMPLE_PERIOD = 4000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AMP_W-1:0]             amplitude,
  input  logic                         amplitude_valid,
  input  logic                         record,
  input  logic                         play,
  output logic                         audio_pwm,
  output logic                         audio_en,
  output logic                         recording,
  output logic                         playing,
  output logic                         full,
  output logic [$clog2(RAM_DEPTH):0]   length
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(SAMPLE_PERIOD);
  audio_state_t state, state_n;
  logic [AMP_W-1:0] ram [RAM_DEPTH];
  logic [AMP_W-1:0] rd_data;
  logic [LW-1:0] rd_addr;
  logic [PW-1:0] per_cnt;
  logic rd_valid, hold, wr, last_wr, start_rec, start_play, load, done;
  always_comb begin
    wr         = (state == RECORD) && amplitude_valid;
    last_wr    = wr && (length == LW'(RAM_DEPTH - 1));
    start_rec  = (state == IDLE) && record && !hold;
    start_play = (state == IDLE) && !record && play && (length != '0);
    load       = (state == PLAY) && rd_valid && (rd_addr != length);
    done       = (state == PLAY) && rd_valid && (rd_addr == length);
    state_n    = start_rec  ? RECORD :
                 start_play ? PLAY :
                 ((state == RECORD) && (!record || last_wr)) ? IDLE :
                 done ? IDLE : state;
    recording  = state == RECORD;
    playing    = state == PLAY;
    audio_en   = playing;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      length   <= '0;
      full     <= 1'b0;
      hold     <= 1'b0;
      rd_addr  <= '0;
      per_cnt  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      rd_valid <= playing && (per_cnt == '0);
      hold     <= record && (hold || last_wr);
      if (start_rec) begin
        length <= '0;
        full   <= 1'b0;
      end else if (wr) begin
        length <= length + 1'b1;
        full   <= last_wr;
      end
      if (start_play) begin
        rd_addr <= '0;
        per_cnt <= '0;
      end else if (playing) begin
        per_cnt <= (per_cnt == PW'(SAMPLE_PERIOD - 1)) ? '0 : per_cnt + 1'b1;
        if (load) rd_addr <= rd_addr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) ram[length[AW-1:0]] <= amplitude;
    rd_data <= ram[rd_addr[AW-1:0]];
  end
  pwm_gen #(.AMP_W(AMP_W)) u_pwm (
    .clk(clk),
    .rst(rst),
    .en(playing),
    .load(load),
    .clr(done),
    .duty_in(rd_data),
    .pwm(audio_pwm)
  );
endmodule

// File: tb/tb_audio_capture_playback.sv
// tb_audio_capture_playback: directed self-checking bench for audio_capture_playback
module tb_audio_capture_playback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] amplitude = '0;
  logic amplitude_valid = 1'b0;
  logic record = 1'b0;
  logic play = 1'b0;
  logic audio_pwm, audio_en, recording, playing, full;
  logic [4:0] length;
  int checks = 0;
  int errors = 0;
  int hi [16];
  int en_bad;
  audio_capture_playback #(.AMP_W(8), .RAM_DEPTH(16), .SAMPLE_PERIOD(256)) dut (
    .clk(clk),
    .rst(rst),
    .amplitude(amplitude),
    .amplitude_valid(amplitude_valid),
    .record(record),
    .play(play),
    .audio_pwm(audio_pwm),
    .audio_en(audio_en),
    .recording(recording),
    .playing(playing),
    .full(full),
    .length(length)
  );
  always #5 clk = ~clk;
  task automatic strobe(input logic [7:0] a);
    @(negedge clk);
    amplitude = a;
    amplitude_valid = 1'b1;
    @(negedge clk);
    amplitude_valid = 1'b0;
  endtask
  task automatic play_measure(input int ns, output int n);
    for (int k = 0; k < 16; k++) hi[k] = 0;
    en_bad = 0;
    @(negedge clk);
    play = 1'b1;
    @(posedge clk);
    #1 play = 1'b0;
    n = 1;
    while (playing && n < ns * 256 + 100) begin
      if (audio_en !== 1'b1) en_bad++;
      if (n >= 20 && (n - 20) % 256 < 128 && (n - 20) / 256 < ns && audio_pwm) hi[(n - 20) / 256]++;
      @(posedge clk);
      #1 n++;
    end
  endtask
  task automatic test_reset;
    checks++;
    if ({audio_pwm, audio_en, recording, playing, full} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000", {audio_pwm, audio_en, recording, playing, full});
    end
    checks++;
    if (length !== 5'd0) begin
      errors++;
      $display("FAIL reset_length got %0d want 0", length);
    end
  endtask
  task automatic test_play_empty;
    int bad = 0;
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (audio_en !== 1'b0 || audio_pwm !== 1'b0 || playing !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL play_empty active_cycles got %0d want 0", bad);
    end
  endtask
  task automatic test_record_play;
    int n;
    @(negedge clk);
    record = 1'b1;
    for (int i = 0; i < 10; i++) strobe(8'(i));
    record = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (length !== 5'd10 || full !== 1'b0 || recording !== 1'b0) begin
      errors++;
      $display("FAIL rec10 length/full/recording got %0d/%b/%b want 10/0/0", length, full, recording);
    end
    play_measure(10, n);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (hi[k] !== k) begin
        errors++;
        $display("FAIL play_duty[%0d] high_cycles got %0d want %0d", k, hi[k], k);
      end
    end
    checks++;
    if (n < 2557 || n > 2563) begin
      errors++;
      $display("FAIL play_duration got %0d want 2560+/-3", n);
    end
    checks++;
    if (en_bad !== 0) begin
      errors++;
      $display("FAIL audio_en_in_play low_cycles got %0d want 0", en_bad);
    end
    @(negedge clk);
    checks++;
    if (audio_pwm !== 1'b0 || audio_en !== 1'b0) begin
      errors++;
      $display("FAIL after_play pwm/en got %b/%b want 0/0", audio_pwm, audio_en);
    end
  endtask
  task automatic test_full;
    int bad = 0;
    @(negedge clk);
    record = 1'b1;
    for (int i = 0; i < 20; i++) begin
      strobe(8'(i + 100));
      if (i == 14) begin
        checks++;
        if (recording !== 1'b1 || length !== 5'd15 || full !== 1'b0) begin
          errors++;
          $display("FAIL full_15 rec/len/full got %b/%0d/%b want 1/15/0", recording, length, full);
        end
      end
      if (i == 15) begin
        checks++;
        if (recording !== 1'b0 || length !== 5'd16 || full !== 1'b1) begin
          errors++;
          $display("FAIL full_16 rec/len/full got %b/%0d/%b want 0/16/1", recording, length, full);
        end
      end
      if (i > 15 && recording !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || length !== 5'd16) begin
      errors++;
      $display("FAIL no_reentry rec_cycles/len got %0d/%0d want 0/16", bad, length);
    end
    record = 1'b0;
    @(negedge clk);
    record = 1'b1;
    @(negedge clk);
    checks++;
    if (recording !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reentry_after_toggle rec/full got %b/%b want 1/0", recording, full);
    end
    record = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_rec_play_same;
    int bad = 0;
    @(negedge clk);
    record = 1'b1;
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    checks++;
    if (recording !== 1'b1) begin
      errors++;
      $display("FAIL rec_priority recording got %b want 1", recording);
    end
    for (int i = 0; i < 3; i++) begin
      strobe(8'(i + 1));
      if (playing !== 1'b0) bad++;
    end
    record = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (playing !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || length !== 5'd3) begin
      errors++;
      $display("FAIL rec_play_same play_cycles/len got %0d/%0d want 0/3", bad, length);
    end
  endtask
  task automatic test_reset_mid_record;
    @(negedge clk);
    record = 1'b1;
    for (int i = 0; i < 5; i++) strobe(8'(i + 7));
    checks++;
    if (length !== 5'd5 || recording !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset len/rec got %0d/%b want 5/1", length, recording);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({audio_pwm, audio_en, recording, playing, full} !== 5'b0 || length !== 5'd0) begin
      errors++;
      $display("FAIL mid_rec_reset outs/len got %b/%0d want 00000/0", {audio_pwm, audio_en, recording, playing, full}, length);
    end
    @(negedge clk);
    rst = 1'b0;
    record = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (recording !== 1'b0 || length !== 5'd0) begin
      errors++;
      $display("FAIL post_reset rec/len got %b/%0d want 0/0", recording, length);
    end
  endtask
  task automatic test_pwm_bounds;
    int n;
    int exp [3];
    exp = '{0, 64, 128};
    @(negedge clk);
    record = 1'b1;
    strobe(8'd0);
    strobe(8'd64);
    strobe(8'd128);
    record = 1'b0;
    @(negedge clk);
    play_measure(3, n);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (hi[k] !== exp[k]) begin
        errors++;
        $display("FAIL pwm_duty[%0d] high_cycles got %0d want %0d", k, hi[k], exp[k]);
      end
    end
    checks++;
    if (n < 765 || n > 771) begin
      errors++;
      $display("FAIL pwm_play_duration got %0d want 768+/-3", n);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_play_empty;
    test_record_play;
    test_full;
    test_rec_play_same;
    test_reset_mid_record;
    test_pwm_bounds;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
